result_writeback_mc: RTL and testbench

//  Parametrised successor to the single-lane result writer. Accepts LANES accumulator results per beat from the GEMM array.

---
 rtl/result_writeback_mc.sv | 205 ++++++++++++++++++++
 tb/tb_result_writeback_mc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_mc.sv
// result_writeback_mc: requantises LANES accumulator results per beat (shift,
// optional round-half-up, optional ReLU, saturation to OUT_W), buffers beats in a
// DEPTH-beat FIFO and serialises them into one output-SRAM write per cycle using the
// output-feature-map layout (addr = k*plane + g*LANES + lane).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, cfg_*              job start pulse and job configuration (latched on start)
//   in_valid/in_ready/in_data input beats, LANES signed ACC_W lanes
//   wr_en/wr_ready/wr_addr/wr_data  SRAM write stream (valid/ready)
//   busy, done, sat_cnt       job status, completion pulse, saturated-lane count
module result_writeback_mc #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned KN_W    = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_plane_size,
  input  logic [KN_W-1:0]          cfg_kernel_num,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_round,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [OUT_W-1:0]         wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              sat_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned LN_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NL_W  = $clog2(LANES + 1);
  localparam int unsigned Q_W   = ACC_W + 1;
  localparam logic signed [Q_W-1:0] QMAX = Q_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] QMIN = ~QMAX;

  // Latched job configuration
  logic [ADDR_W-1:0]  plane_r;
  logic [KN_W-1:0]    knum_r;
  logic [SHIFT_W-1:0] shift_r;
  logic               round_r, relu_r;

  // Input-side layout counters
  logic [KN_W-1:0]    kidx;
  logic [ADDR_W-1:0]  koff, pix_base;
  logic               all_in, zero_job;

  // Beat FIFO
  logic [LANES*OUT_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0]      mem_base [DEPTH];
  logic [NL_W-1:0]        mem_n    [DEPTH];
  logic                   mem_last [DEPTH];
  logic [PTR_W-1:0]       wptr, rptr;
  logic [CNT_W-1:0]       count;
  logic [LN_W-1:0]        rd_lane;

  // Output register tags
  logic out_tail, out_final;

  logic [ADDR_W:0]        rem;
  logic [NL_W-1:0]        beat_n, head_n, sat_sum;
  logic                   last_group, last_kernel, final_beat;
  logic [LANES*OUT_W-1:0] beat_data;
  logic [OUT_W:0]         qr;
  logic [CNT_W-1:0]       occ;
  logic                   push, load, pop, accept, head_tail;
  logic [16:0]            sat_next;

  // Requantise one lane; returns {saturated, value}
  function automatic logic [OUT_W:0] quantise(input logic [ACC_W-1:0] acc,
                                              input logic [SHIFT_W-1:0] sh,
                                              input logic rnd, input logic relu);
    logic signed [Q_W-1:0] t;
    logic signed [Q_W-1:0] q;
    logic                  sat;
    t = $signed({acc[ACC_W-1], acc});
    if (rnd && sh != '0) t = t + $signed(Q_W'(1) << (sh - SHIFT_W'(1)));
    q = t >>> sh;
    if (relu && q[Q_W-1]) q = '0;
    sat = 1'b0;
    if (q > QMAX) begin
      q = QMAX;
      sat = 1'b1;
    end else if (q < QMIN) begin
      q = QMIN;
      sat = 1'b1;
    end
    return {sat, q[OUT_W-1:0]};
  endfunction

  // Lanes present in the current group (partial last group masks the rest)
  assign rem         = {1'b0, plane_r} - {1'b0, pix_base};
  assign beat_n      = (rem >= (ADDR_W+1)'(LANES)) ? NL_W'(LANES) : NL_W'(rem);
  assign last_group  = ({1'b0, pix_base} + (ADDR_W+1)'(LANES)) >= {1'b0, plane_r};
  assign last_kernel = (kidx == knum_r - KN_W'(1));
  assign final_beat  = last_group && last_kernel;

  // Quantise all lanes of the incoming beat, count saturations on unmasked lanes
  always_comb begin
    beat_data = '0;
    sat_sum   = '0;
    qr        = '0;
    for (int i = 0; i < LANES; i++) begin
      qr = quantise(in_data[i*ACC_W +: ACC_W], shift_r, round_r, relu_r);
      beat_data[i*OUT_W +: OUT_W] = qr[OUT_W-1:0];
      if (NL_W'(i) < beat_n && qr[OUT_W]) sat_sum = sat_sum + NL_W'(1);
    end
  end

  // A beat stays counted as buffered until its last lane is accepted; the head is
  // popped when that lane moves to the output register, so count the held tail too.
  assign occ       = count + CNT_W'(wr_en & out_tail);
  assign in_ready  = busy && !all_in && (occ < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign accept    = wr_en && wr_ready;
  assign load      = busy && (!wr_en || wr_ready) && (count != '0);
  assign head_n    = mem_n[rptr];
  assign head_tail = (NL_W'(rd_lane) == head_n - NL_W'(1));
  assign pop       = load && head_tail;
  assign sat_next  = {1'b0, sat_cnt} + 17'(sat_sum);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= beat_data;
      mem_base[wptr] <= koff + pix_base;
      mem_n[wptr]    <= beat_n;
      mem_last[wptr] <= final_beat;
    end
  end

  // Control, counters and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plane_r <= '0; knum_r <= '0; shift_r <= '0; round_r <= 1'b0; relu_r <= 1'b0;
      kidx <= '0; koff <= '0; pix_base <= '0; all_in <= 1'b0; zero_job <= 1'b0;
      wptr <= '0; rptr <= '0; count <= '0; rd_lane <= '0;
      out_tail <= 1'b0; out_final <= 1'b0;
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
      busy <= 1'b0; done <= 1'b0; sat_cnt <= '0;
    end else if (start) begin
      // New job (or abort of the running one): relatch and flush everything
      plane_r <= cfg_plane_size; knum_r <= cfg_kernel_num; shift_r <= cfg_shift;
      round_r <= cfg_round; relu_r <= cfg_relu;
      kidx <= '0; koff <= '0; pix_base <= '0;
      all_in   <= (cfg_plane_size == '0) || (cfg_kernel_num == '0);
      zero_job <= (cfg_plane_size == '0) || (cfg_kernel_num == '0);
      wptr <= '0; rptr <= '0; count <= '0; rd_lane <= '0;
      out_tail <= 1'b0; out_final <= 1'b0;
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
      busy <= 1'b1; done <= 1'b0; sat_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (busy && zero_job) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        zero_job <= 1'b0;
      end
      if (push) begin
        wptr   <= wptr + PTR_W'(1);
        all_in <= final_beat;
        sat_cnt <= sat_next[16] ? 16'hFFFF : sat_next[15:0];
        if (last_kernel) begin
          kidx     <= '0;
          koff     <= '0;
          pix_base <= pix_base + ADDR_W'(LANES);
        end else begin
          kidx <= kidx + KN_W'(1);
          koff <= koff + plane_r;
        end
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (load) begin
        wr_en     <= 1'b1;
        wr_addr   <= mem_base[rptr] + ADDR_W'(rd_lane);
        wr_data   <= mem_data[rptr][rd_lane*OUT_W +: OUT_W];
        out_tail  <= head_tail;
        out_final <= head_tail && mem_last[rptr];
        rd_lane   <= head_tail ? '0 : rd_lane + LN_W'(1);
        if (head_tail) rptr <= rptr + PTR_W'(1);
      end else if (accept) begin
        wr_en <= 1'b0;
      end
      if (accept && out_final) begin
        done      <= 1'b1;
        busy      <= 1'b0;
        wr_en     <= 1'b0;
        out_tail  <= 1'b0;
        out_final <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_writeback_mc.sv
// tb_result_writeback_mc: randomized scoreboard bench for result_writeback_mc.
// The driver computes every expected SRAM write from the layout/quantisation rules
// when a beat is accepted; a negedge monitor pops and compares each accepted write.
module tb_result_writeback_mc;

  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst, start, cfg_round, cfg_relu, in_valid, in_ready;
  logic [ADDR_W-1:0]      cfg_plane_size;
  logic [7:0]             cfg_kernel_num;
  logic [4:0]             cfg_shift;
  logic [LANES*ACC_W-1:0] in_data;
  logic                   wr_en, wr_ready, busy, done;
  logic [ADDR_W-1:0]      wr_addr;
  logic [OUT_W-1:0]       wr_data;
  logic [15:0]            sat_cnt;

  result_writeback_mc dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_plane_size(cfg_plane_size), .cfg_kernel_num(cfg_kernel_num),
    .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int n_writes_job = 0;
  int done_cnt = 0;
  int exp_sat = 0;
  int stall_cycles = 0;
  int rdy_pct = 100;
  int j_plane, j_knum, j_shift;
  bit j_round, j_relu;
  int cur[LANES];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference requantisation: floor division by 2^shift, ReLU, clamp
  function automatic int ref_q(input int acc, output bit sat);
    longint t, d, q;
    t = acc;
    if (j_round && j_shift > 0) t = t + (longint'(1) << (j_shift - 1));
    d = longint'(1) << j_shift;
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    if (j_relu && q < 0) q = 0;
    sat = 1'b0;
    if (q > 127) begin q = 127; sat = 1'b1; end
    else if (q < -128) begin q = -128; sat = 1'b1; end
    return int'(q);
  endfunction

  task automatic load_beat(input int mode);
    int tbl[LANES];
    tbl = '{5, 6, -6, 1000, -1000, 0, 7, -7};
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0:       cur[i] = 256;
        1:       cur[i] = int'($urandom_range(0, 4000)) - 2000;
        2:       cur[i] = int'($urandom);
        default: cur[i] = tbl[i];
      endcase
      in_data[i*ACC_W +: ACC_W] = cur[i];
    end
  endtask

  // SRAM-side ready: forced low for stall_cycles, otherwise random
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cycles > 0) begin
        stall_cycles--;
        wr_ready = 1'b0;
      end else begin
        wr_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // Monitor: scoreboard pop on each accepted write, hold check while stalled
  logic            prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [OUT_W-1:0]  prev_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_en", wr_en, 1);
        check("stall_hold_addr", wr_addr, prev_addr);
        check("stall_hold_data", wr_data, prev_data);
      end
      if (wr_en && wr_ready) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0d, no write expected", wr_addr, $signed(wr_data));
        end else begin
          check("wr_addr", wr_addr, exp_addr_q.pop_front());
          check("wr_data", $signed(wr_data), exp_data_q.pop_front());
        end
        n_writes_job++;
      end
      if (done) done_cnt++;
      prev_stall = wr_en && !wr_ready && !start;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge
  task automatic do_start(input int plane, input int knum, input int shift, input bit rnd, input bit relu);
    j_plane = plane; j_knum = knum; j_shift = shift; j_round = rnd; j_relu = relu;
    cfg_plane_size = ADDR_W'(plane);
    cfg_kernel_num = 8'(knum);
    cfg_shift = 5'(shift);
    cfg_round = rnd;
    cfg_relu = relu;
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    n_writes_job = 0;
    done_cnt = 0;
    exp_sat = 0;
  endtask

  task automatic feed(input int mode, input bit stall_probe);
    int g, k, taken, cyc, nb, nl;
    bit s;
    int q;
    g = 0; k = 0; taken = 0; cyc = 0;
    nb = ((j_plane + LANES - 1) / LANES) * j_knum;
    load_beat(mode);
    while (taken < nb) begin
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        nl = j_plane - g * LANES;
        if (nl > LANES) nl = LANES;
        for (int i = 0; i < nl; i++) begin
          q = ref_q(cur[i], s);
          exp_addr_q.push_back((k * j_plane + g * LANES + i) & 16'hFFFF);
          exp_data_q.push_back(q);
          exp_sat += int'(s);
        end
        taken++;
        got = 1'b1;
        k++;
        if (k == j_knum) begin k = 0; g++; end
      end
      if (stall_probe && cyc == 12) check("beats_buffered_at_stall", taken, DEPTH);
      cyc++;
      if (cyc > 5000) begin
        n_cmp++;
        n_err++;
        $display("FAIL feed_timeout: got %0d beats taken, expected %0d", taken, nb);
        break;
      end
      @(posedge clk); #1;
      if (got) load_beat(mode);
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input string name);
    int cyc;
    cyc = 0;
    @(negedge clk);
    check({name, "_in_ready_after_last"}, in_ready, 0);
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_write_count"}, n_writes_job, j_plane * j_knum);
    check({name, "_leftover_expected"}, exp_addr_q.size(), 0);
    check({name, "_sat_cnt"}, sat_cnt, exp_sat);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_wr_en_after"}, wr_en, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_plane_size = '0; cfg_kernel_num = '0; cfg_shift = '0; cfg_round = 1'b0; cfg_relu = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: basic 16x2 layout, constant 0x100 >> 4 = 16
    rdy_pct = 100;
    do_start(16, 2, 4, 0, 0);
    feed(0, 0);
    finish_job("t1");

    // T2: partial last group
    rdy_pct = 80;
    do_start(9, 3, 4, 0, 0);
    feed(1, 0);
    finish_job("t2");

    // T3: rounding and saturation, then the same values with ReLU
    rdy_pct = 100;
    do_start(8, 1, 2, 1, 0);
    feed(3, 0);
    finish_job("t3");
    check("t3_sat_two", sat_cnt, 2);
    do_start(8, 1, 2, 1, 1);
    feed(3, 0);
    finish_job("t3_relu");

    // T4: back-pressure with in_valid held high
    rdy_pct = 50;
    do_start(16, 2, 4, 0, 0);
    stall_cycles = 20;
    feed(0, 1);
    finish_job("t4");

    // T5: abort mid-job after 10 writes
    rdy_pct = 70;
    do_start(16, 2, 4, 0, 0);
    feed(1, 0);
    cyc = 0;
    while (n_writes_job < 10 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_reached_10_writes", (n_writes_job >= 10) ? 1 : 0, 1);
    check("t5_no_done_before_abort", done_cnt, 0);
    do_start(16, 2, 3, 0, 0);
    @(negedge clk);
    check("t5_wr_en_after_abort", wr_en, 0);
    check("t5_in_ready_after_abort", in_ready, 1);
    check("t5_sat_cleared", sat_cnt, 0);
    check("t5_busy_after_abort", busy, 1);
    @(posedge clk); #1;
    feed(1, 0);
    finish_job("t5");

    // Zero-sized job: one busy cycle then a done pulse, no writes
    do_start(0, 2, 0, 0, 0);
    @(negedge clk);
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy_after", busy, 0);
    @(negedge clk);
    check("zero_done_single", done, 0);
    check("zero_no_writes", n_writes_job, 0);
    @(posedge clk); #1;

    // Random jobs
    for (int r = 0; r < 4; r++) begin
      rdy_pct = int'($urandom_range(30, 100));
      do_start(int'($urandom_range(1, 40)), int'($urandom_range(1, 4)), int'($urandom_range(0, 12)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      feed(int'($urandom_range(1, 2)), 0);
      finish_job("rand");
    end

    // T6: reset during a stalled write
    do_start(16, 2, 4, 0, 0);
    stall_cycles = 1000;
    load_beat(0);
    in_valid = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (wr_en) break;
      cyc++;
    end
    check("t6_write_pending", wr_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_wr_en", wr_en, 0);
    check("t6_wr_addr", wr_addr, 0);
    check("t6_wr_data", wr_data, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_sat_cnt", sat_cnt, 0);
    check("t6_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_in_ready_after_rst", in_ready, 0);
    in_valid = 1'b0;
    stall_cycles = 0;
    exp_addr_q.delete();
    exp_data_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
